adder_stim_checker: RTL and testbench
=====================================

Name: adder_stim_checker

Overview:
- On-board self-test driver for the 4-bit carry-lookahead add/subtract unit.
- Owns the operand side of the adder interface: drives a, b, c_in and mode, then samples sum and c_out.
- Sweeps all 1024 input combinations and compares each result against an internal golden model.
- Reports pass/fail, an error count and the first failing vector. The results go to Nexys A7 LEDs or to a simulation bench.

Parameters:
- SETTLE_CYCLES, 2: clock cycles allowed for the combinational DUT to settle after each new vector. Legal range ≥1.
- ERR_W, 11: width of the error counter. The counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep when in IDLE or DONE.
- dut_a  output  4  operand A to the adder.
- dut_b  output  4  operand B to the adder.
- dut_c_in  output  1  carry-in to the adder.
- dut_mode  output  1  0 = add, 1 = subtract (adder inverts b internally).
- dut_sum  input  4  adder sum.
- dut_c_out  input  1  adder carry-out.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high once a sweep completes; held.
- pass  output  1  done && err_count==0.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- first_fail_valid  output  1  a mismatch has been recorded this sweep.
- first_fail_vec  output  10  index of the first mismatching vector.

Behaviour:
- Reset: one clock, synchronous, active-high. While reset is high, all outputs are 0 and the state is IDLE. This applies mid-sweep too; the sweep is abandoned with no partial results kept.
- Vector index idx[9:0] maps to the drive outputs as:
  - dut_a = idx[3:0]
  - dut_b = idx[7:4]
  - dut_c_in = idx[8]
  - dut_mode = idx[9]
- Sweep order: idx runs 0 to 1023 ascending.
- Golden model (5-bit result {c_out, sum}):
  - mode=0: a + b + c_in.
  - mode=1: a + (~b & 4'hF) + c_in.
  - All arithmetic is zero-extended to 5 bits.
- State IDLE:
  - start=1: idx←0, err_count←0, first_fail_valid←0, first_fail_vec←0, drive outputs←vector 0, settle counter←SETTLE_CYCLES-1, next state SETTLE.
- State SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles, then goes to CHECK.
- State CHECK (one cycle):
  - Compare {dut_c_out, dut_sum} against the golden value of the currently driven vector.
  - On mismatch, err_count increments, holding at 2^ERR_W-1.
  - On mismatch with first_fail_valid=0: set first_fail_valid←1 and first_fail_vec←idx.
  - If idx==1023, go to DONE.
  - Otherwise idx←idx+1, drive the next vector, reload the settle counter, and go to SETTLE.
- State DONE:
  - done=1, busy=0.
  - Results are held and drive outputs keep the last vector.
  - start=1 restarts the sweep exactly as from IDLE.
- Timing:
  - busy=1 in SETTLE and CHECK; 0 otherwise.
  - Drive outputs are registered and change only on the CHECK→SETTLE edge or on the start edge.
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 1024·(SETTLE_CYCLES+1) cycles after the start-sampling edge.
- start while busy is ignored.
- start and reset asserted together: reset wins.
- pass is combinational from done and err_count. It is 0 whenever done=0.

Test Plan:
- Correct behavioural adder model, SETTLE_CYCLES=2, one start pulse → busy for 3072 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- DUT sum[0] stuck at 0 → done=1, pass=0, err_count=512, first_fail_vec=1 (a=1, b=0, c_in=0, mode=0, expected sum=1).
- Fault injected only at a=5, b=2, c_in=1, mode=1, which must return sum=3, c_out=1 → err_count=1, first_fail_vec=805. Every other vector matches.
- c_out always inverted with ERR_W=8 → err_count saturates at 255, first_fail_vec=0, pass=0.
- Reset asserted at cycle 100 of a sweep → next cycle busy=0, done=0, all drive outputs 0, err_count=0. A subsequent start completes a full clean sweep with pass=1.
- start re-pulsed mid-sweep → ignored; done timing unchanged. start pulsed in DONE after a failing sweep, with the fault removed → err_count and first_fail_valid cleared, new sweep ends with pass=1.

Source files
------------

// File: rtl/adder_stim_checker.sv
// Self-test driver for the 4-bit add/subtract unit: sweeps all 1024 operand
// combinations, checks each result against a golden model and records errors.
module adder_stim_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    output logic             dut_c_in,
    output logic             dut_mode,
    input  logic [3:0]       dut_sum,
    input  logic             dut_c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [9:0]       first_fail_vec
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [9:0]       ffvec_q, ffvec_d;

    logic [3:0]       b_eff;
    logic [4:0]       golden;
    logic             mismatch;

    // Subtract mode mirrors the adder's internal inversion of b.
    always_comb begin
        b_eff    = idx_q[9] ? ~idx_q[7:4] : idx_q[7:4];
        golden   = {1'b0, idx_q[3:0]} + {1'b0, b_eff} + {4'b0000, idx_q[8]};
        mismatch = ({dut_c_out, dut_sum} != golden);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSettle;
                    idx_d   = '0;
                    cnt_d   = SETTLE_LOAD;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = idx_q;
                    end
                end
                if (idx_q == 10'd1023) begin
                    state_d = StDone;
                end else begin
                    state_d = StSettle;
                    idx_d   = idx_q + 10'd1;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    always_comb begin
        dut_a            = idx_q[3:0];
        dut_b            = idx_q[7:4];
        dut_c_in         = idx_q[8];
        dut_mode         = idx_q[9];
        busy             = (state_q == StSettle) || (state_q == StCheck);
        done             = (state_q == StDone);
        pass             = done && (err_q == '0);
        err_count        = err_q;
        first_fail_valid = ffv_q;
        first_fail_vec   = ffvec_q;
    end

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: behavioural adder with selectable faults,
// expected sweep results queued at start and compared when done rises.
module tb_adder_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [3:0]  dut_a, dut_b, dut_sum;
    logic        dut_c_in, dut_mode, dut_c_out;
    logic        busy, done, pass, first_fail_valid;
    logic [10:0] err_count;
    logic [9:0]  first_fail_vec;
    int          fault;

    logic        reset8, start8;
    logic [3:0]  a8, b8, sum8;
    logic        c_in8, mode8, c_out8;
    logic        busy8, done8, pass8, ffv8;
    logic [7:0]  err8;
    logic [9:0]  ffvec8;

    adder_stim_checker #(.SETTLE_CYCLES(2), .ERR_W(11)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_c_in(dut_c_in), .dut_mode(dut_mode),
        .dut_sum(dut_sum), .dut_c_out(dut_c_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
    );

    adder_stim_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8),
        .dut_a(a8), .dut_b(b8), .dut_c_in(c_in8), .dut_mode(mode8),
        .dut_sum(sum8), .dut_c_out(c_out8),
        .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
        .first_fail_valid(ffv8), .first_fail_vec(ffvec8)
    );

    // Fault 1: sum[0] stuck low. Fault 2: wrong result only at vector 805.
    always_comb begin
        logic [3:0] bb;
        logic [4:0] res;
        bb  = dut_mode ? ~dut_b : dut_b;
        res = {1'b0, dut_a} + {1'b0, bb} + {4'b0000, dut_c_in};
        if (fault == 1) res[0] = 1'b0;
        if (fault == 2 && {dut_mode, dut_c_in, dut_b, dut_a} == 10'd805) res = 5'h00;
        {dut_c_out, dut_sum} = res;
    end

    always_comb begin
        logic [3:0] bb;
        logic [4:0] res;
        bb  = mode8 ? ~b8 : b8;
        res = {1'b0, a8} + {1'b0, bb} + {4'b0000, c_in8};
        sum8   = res[3:0];
        c_out8 = ~res[4];
    end

    typedef struct {
        int err;
        int ffv;
        int ffvec;
        int pas;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int err, input int ffv, input int ffvec, input int pas);
        exp_t e;
        e.err = err; e.ffv = ffv; e.ffvec = ffvec; e.pas = pas;
        sb.push_back(e);
    endtask

    task automatic run_sweep(input string name, input bit repulse);
        int cycles;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({name, "_busy_at_start"}, busy, 1);
        check({name, "_cleared_err"}, err_count, 0);
        check({name, "_cleared_ffv"}, first_fail_valid, 0);
        check({name, "_done_low"}, done, 0);
        cycles = 0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = (repulse && cycles == 500);
        end
        start = 1'b0;
        check({name, "_done_latency"}, cycles, 3072);
        check({name, "_busy_in_done"}, busy, 0);
        check({name, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_err_count"}, err_count, e.err);
            check({name, "_ffv"}, first_fail_valid, e.ffv);
            check({name, "_ffvec"}, first_fail_vec, e.ffvec);
            check({name, "_pass"}, pass, e.pas);
        end
    endtask

    initial begin
        int cycles;
        reset = 1'b1; start = 1'b0; fault = 0;
        reset8 = 1'b1; start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_ffv", first_fail_valid, 0);
        check("rst_ffvec", first_fail_vec, 0);
        check("rst_drive", {dut_mode, dut_c_in, dut_b, dut_a}, 0);
        reset = 1'b0; reset8 = 1'b0;

        push_exp(0, 0, 0, 1);
        run_sweep("clean", 1'b0);

        fault = 1;
        push_exp(512, 1, 1, 0);
        run_sweep("sum0_stuck", 1'b0);
        check("done_hold_drive", {dut_mode, dut_c_in, dut_b, dut_a}, 1023);

        fault = 0;
        push_exp(0, 0, 0, 1);
        run_sweep("restart_done", 1'b0);

        fault = 2;
        push_exp(1, 1, 805, 0);
        run_sweep("single_805", 1'b0);

        // Abandon a faulty sweep at cycle 100 with reset and start both high.
        fault = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_ffv", first_fail_valid, 0);
        check("mid_rst_drive", {dut_mode, dut_c_in, dut_b, dut_a}, 0);
        reset = 1'b0; start = 1'b0; fault = 0;

        push_exp(0, 0, 0, 1);
        run_sweep("after_rst_repulse", 1'b1);

        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        cycles = 0;
        while (!done8 && cycles < 5000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check("sat_done_latency", cycles, 3072);
        check("sat_err_count", err8, 255);
        check("sat_ffv", ffv8, 1);
        check("sat_ffvec", ffvec8, 0);
        check("sat_pass", pass8, 0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
